// File: rtl/spatz_vred_accumulator.sv
// Vector reduction accumulator: folds the SIMD lane's element stream into one
// scalar (sum/and/or/xor/min/max) and hands it back over a valid/ready port.
module spatz_vred_accumulator #(
    parameter int unsigned Width   = 8,
    parameter int unsigned VlWidth = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [2:0]         cmd_op_i,
    input  logic               cmd_signed_i,
    input  logic [VlWidth-1:0] cmd_vl_i,
    input  logic [Width-1:0]   cmd_init_i,
    input  logic               elem_valid_i,
    output logic               elem_ready_o,
    input  logic [Width-1:0]   elem_data_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [Width-1:0]   res_data_o,
    output logic               busy_o
);

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MIN = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q;
    logic [2:0]           op_q;
    logic                 signed_q;
    logic [VlWidth-1:0]   cnt_q;
    logic [Width-1:0]     acc_q;

    // One fold step; min/max compare in Width+1 bits so signed and unsigned
    // share a single signed comparator. Ties keep the accumulator.
    function automatic logic [Width-1:0] fold(
        input logic [2:0]       op,
        input logic             sgn,
        input logic [Width-1:0] acc,
        input logic [Width-1:0] elem
    );
        logic [Width:0]   acc_ext;
        logic [Width:0]   elem_ext;
        logic             elem_lt;
        logic             elem_gt;
        logic [Width-1:0] result;
        acc_ext  = {sgn & acc[Width-1], acc};
        elem_ext = {sgn & elem[Width-1], elem};
        elem_lt  = $signed(elem_ext) < $signed(acc_ext);
        elem_gt  = $signed(elem_ext) > $signed(acc_ext);
        result   = acc;
        case (op)
            OP_SUM:  result = acc + elem;
            OP_AND:  result = acc & elem;
            OP_OR:   result = acc | elem;
            OP_XOR:  result = acc ^ elem;
            OP_MIN:  result = elem_lt ? elem : acc;
            OP_MAX:  result = elem_gt ? elem : acc;
            default: result = acc;
        endcase
        return result;
    endfunction

    // Control and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q     <= cmd_op_i;
                        signed_q <= cmd_signed_i;
                        cnt_q    <= cmd_vl_i;
                        acc_q    <= cmd_init_i;
                        state_q  <= (cmd_vl_i == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (elem_valid_i) begin
                        acc_q <= fold(op_q, signed_q, acc_q, elem_data_i);
                        cnt_q <= cnt_q - VlWidth'(1);
                        if (cnt_q == VlWidth'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register directly.
    assign cmd_ready_o  = (state_q == IDLE);
    assign elem_ready_o = (state_q == ACCUM);
    assign res_valid_o  = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign res_data_o   = acc_q;

endmodule
